// File: rtl/sample_acquisition_az_if.sv
// Control, parameter and ADC-handshake signals of the auto-zero acquisition sequencer.
// The master modport is the sequencer; the slave modport is the register block / ADC side.
interface sample_acquisition_az_if;
  logic        arm_i;
  logic [23:0] p_clk_count_precharge;
  logic [3:0]  p_azmux_hi;
  logic [3:0]  p_azmux_lo;
  logic        adc_measure_valid_i;
  logic        adc_measure_trig_o;
  logic        sw_pc_ctl_o;
  logic [3:0]  azmux_o;
  logic        meas_complete_o;
  logic [2:0]  az_status_o;
  logic [7:0]  sample_count_o;

  modport master (
    input  arm_i, p_clk_count_precharge, p_azmux_hi, p_azmux_lo, adc_measure_valid_i,
    output adc_measure_trig_o, sw_pc_ctl_o, azmux_o, meas_complete_o, az_status_o,
    sample_count_o
  );

  modport slave (
    output arm_i, p_clk_count_precharge, p_azmux_hi, p_azmux_lo, adc_measure_valid_i,
    input  adc_measure_trig_o, sw_pc_ctl_o, azmux_o, meas_complete_o, az_status_o,
    sample_count_o
  );
endinterface

// File: rtl/sample_acquisition_az.sv
// Auto-zero sample-acquisition sequencer: alternates HI/LO inputs, each phase a precharge
// interval followed by a triggered ADC measurement. All outputs are registered.
module sample_acquisition_az #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input logic                      clk,
  input logic                      reset_n,
  sample_acquisition_az_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, PC_HI, MEAS_HI, PC_LO, MEAS_LO, FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] pc_len_q;
  logic [3:0]  code_hi_q, code_lo_q;

  logic        trig_q, trig_d;
  logic        sw_pc_q, sw_pc_d;
  logic [3:0]  azmux_q, azmux_d;
  logic        mc_q, mc_d;
  logic [2:0]  status_q, status_d;
  logic [7:0]  count_q, count_d;

  logic        arm_start;
  logic        in_meas;
  logic        valid_ok;
  logic        pc_done;
  logic        timed_out;
  logic [3:0]  code_hi_eff;

  assign arm_start = (state_q == IDLE) && bus.arm_i;
  assign in_meas   = (state_q == MEAS_HI) || (state_q == MEAS_LO);
  // A counter of zero marks the trigger cycle, in which a valid cannot belong to this measurement.
  assign valid_ok  = in_meas && (cnt_q != 24'd0) && bus.adc_measure_valid_i;
  assign pc_done   = (cnt_q == pc_len_q);
  assign timed_out = (cnt_q == TIMEOUT - 24'd1);
  // The hi code is latched on the same edge that first drives it, so bypass the latch then.
  assign code_hi_eff = arm_start ? bus.p_azmux_hi : code_hi_q;

  // NOTE: sequential blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 24'd1;
    if ((state_q != IDLE) && !bus.arm_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (bus.arm_i) state_d = PC_HI;
        end
        PC_HI: if (pc_done) begin
          state_d = MEAS_HI;
          cnt_d   = '0;
        end
        PC_LO: if (pc_done) begin
          state_d = MEAS_LO;
          cnt_d   = '0;
        end
        MEAS_HI: if (valid_ok) begin
          state_d = PC_LO;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = FAULT;
          cnt_d   = '0;
        end
        MEAS_LO: if (valid_ok) begin
          state_d = PC_HI;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = FAULT;
          cnt_d   = '0;
        end
        FAULT:   cnt_d = '0;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    trig_d   = 1'b0;
    sw_pc_d  = 1'b0;
    azmux_d  = 4'b0000;
    status_d = 3'b000;
    mc_d     = mc_q;
    count_d  = count_q;
    case (state_d)
      PC_HI: begin
        azmux_d  = code_hi_eff;
        status_d = 3'b011;
      end
      MEAS_HI: begin
        azmux_d  = code_hi_q;
        sw_pc_d  = 1'b1;
        status_d = 3'b011;
        trig_d   = (state_q != MEAS_HI);
        mc_d     = 1'b0;
      end
      PC_LO: begin
        azmux_d  = code_lo_q;
        status_d = 3'b001;
      end
      MEAS_LO: begin
        azmux_d  = code_lo_q;
        status_d = 3'b001;
        trig_d   = (state_q != MEAS_LO);
      end
      FAULT: begin
        status_d = 3'b100;
        mc_d     = 1'b0;
      end
      default: mc_d = 1'b0;
    endcase
    if ((state_q == MEAS_LO) && (state_d == PC_HI)) begin
      mc_d    = 1'b1;
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pc_len_q  <= '0;
      code_hi_q <= '0;
      code_lo_q <= '0;
      trig_q    <= 1'b0;
      sw_pc_q   <= 1'b0;
      azmux_q   <= '0;
      mc_q      <= 1'b0;
      status_q  <= '0;
      count_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      sw_pc_q  <= sw_pc_d;
      azmux_q  <= azmux_d;
      mc_q     <= mc_d;
      status_q <= status_d;
      count_q  <= count_d;
      if (arm_start) begin
        pc_len_q  <= bus.p_clk_count_precharge;
        code_hi_q <= bus.p_azmux_hi;
        code_lo_q <= bus.p_azmux_lo;
      end
    end
  end

  assign bus.adc_measure_trig_o = trig_q;
  assign bus.sw_pc_ctl_o        = sw_pc_q;
  assign bus.azmux_o            = azmux_q;
  assign bus.meas_complete_o    = mc_q;
  assign bus.az_status_o        = status_q;
  assign bus.sample_count_o     = count_q;

endmodule

// File: tb/tb_sample_acquisition_az.sv
// Bench for sample_acquisition_az: phase timelines are derived from precharge length and
// valid delay, and every cycle's outputs are compared to that expected timeline.
module tb_sample_acquisition_az;
  localparam logic [23:0] TO = 24'd16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sample_acquisition_az_if bus ();
  sample_acquisition_az #(.TIMEOUT(TO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks_total = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  int         exp_count = 0;
  logic       exp_mc = 1'b0;
  int         lat_p;
  logic [3:0] lat_hi, lat_lo;

  function automatic logic [17:0] pack(input logic trig, input logic sw, input logic [3:0] mux,
                                       input logic mc, input logic [2:0] st, input logic [7:0] cnt);
    return {trig, sw, mux, mc, st, cnt};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = {bus.adc_measure_trig_o, bus.sw_pc_ctl_o, bus.azmux_o, bus.meas_complete_o,
           bus.az_status_o, bus.sample_count_o};
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed trig/sw/mux/mc/st/cnt=%h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n cycles of precharge; stray valid pulses during precharge must have no effect.
  task automatic pc_phase(input logic is_hi, input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      check(is_hi ? "pc_hi" : "pc_lo",
            pack(1'b0, 1'b0, code, exp_mc, {1'b0, is_hi, 1'b1}, 8'(exp_count)));
      bus.adc_measure_valid_i = 1'($urandom_range(0, 1));
      step();
      bus.adc_measure_valid_i = 1'b0;
    end
  endtask

  // Trigger cycle plus d wait cycles; valid is driven d cycles after the trigger.
  task automatic meas_phase(input logic is_hi, input logic [3:0] code, input int d,
                            input logic early);
    if (is_hi) exp_mc = 1'b0;
    for (int j = 0; j <= d; j++) begin
      check(is_hi ? "meas_hi" : "meas_lo",
            pack(j == 0, is_hi, code, exp_mc, {1'b0, is_hi, 1'b1}, 8'(exp_count)));
      bus.adc_measure_valid_i = (j == d) || ((j == 0) && early);
      step();
      bus.adc_measure_valid_i = 1'b0;
    end
    if (!is_hi) begin
      exp_count = (exp_count + 1) % 256;
      exp_mc    = 1'b1;
    end
  endtask

  task automatic arm_start(input int p, input logic [3:0] hi, input logic [3:0] lo);
    bus.p_clk_count_precharge = 24'(p);
    bus.p_azmux_hi = hi;
    bus.p_azmux_lo = lo;
    lat_p  = p;
    lat_hi = hi;
    lat_lo = lo;
    bus.arm_i = 1'b1;
    step();
    exp_mc = 1'b0;
    bus.p_clk_count_precharge = 24'($urandom_range(0, 15));
    bus.p_azmux_hi = 4'($urandom);
    bus.p_azmux_lo = 4'($urandom);
  endtask

  task automatic pair(input int d_hi, input int d_lo, input logic early);
    pc_phase(1'b1, lat_hi, lat_p + 1);
    meas_phase(1'b1, lat_hi, d_hi, early);
    pc_phase(1'b0, lat_lo, lat_p + 1);
    meas_phase(1'b0, lat_lo, d_lo, 1'b0);
  endtask

  task automatic disarm_check(input string tag);
    bus.arm_i = 1'b0;
    step();
    bus.adc_measure_valid_i = 1'b0;
    exp_mc = 1'b0;
    check(tag, pack(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 8'(exp_count)));
  endtask

  initial begin
    bus.arm_i = 1'b0;
    bus.p_clk_count_precharge = '0;
    bus.p_azmux_hi = '0;
    bus.p_azmux_lo = '0;
    bus.adc_measure_valid_i = 1'b0;

    #12;
    check("reset", pack(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 8'd0));
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle", pack(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 8'd0));
    end

    // Single directed pair.
    arm_start(3, 4'b1001, 4'b0011);
    pair(5, 5, 1'b0);
    check("single_done", pack(1'b0, 1'b0, 4'b1001, 1'b1, 3'b011, 8'd1));
    disarm_check("single_idle");

    // Valid coincident with the trigger is ignored.
    arm_start(1, 4'h6, 4'hC);
    pair(4, 2, 1'b1);
    disarm_check("early_idle");

    // Randomized rounds, parameters perturbed while armed.
    for (int r = 0; r < 6; r++) begin
      arm_start(int'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        pair(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
      check("round_end", pack(1'b0, 1'b0, lat_hi, 1'b1, 3'b011, 8'(exp_count)));
      disarm_check("round_idle");
    end

    // Abort during PC_LO with a coincident valid, then re-arm with new parameters.
    arm_start(4, 4'h3, 4'hE);
    pc_phase(1'b1, lat_hi, 5);
    meas_phase(1'b1, lat_hi, 2, 1'b0);
    pc_phase(1'b0, lat_lo, 2);
    bus.adc_measure_valid_i = 1'b1;
    disarm_check("abort_pc_lo");
    arm_start(1, 4'hA, 4'h5);
    pair(1, 3, 1'b0);
    pc_phase(1'b1, lat_hi, 2);
    meas_phase(1'b1, lat_hi, 1, 1'b0);
    pc_phase(1'b0, lat_lo, 2);
    check("abort_ml_trig", pack(1'b1, 1'b0, lat_lo, 1'b0, 3'b001, 8'(exp_count)));
    step();
    check("abort_ml_wait", pack(1'b0, 1'b0, lat_lo, 1'b0, 3'b001, 8'(exp_count)));
    bus.adc_measure_valid_i = 1'b1;
    disarm_check("abort_meas_lo");

    // Timeout: no valid for TO measure cycles.
    arm_start(2, 4'h7, 4'h8);
    pc_phase(1'b1, lat_hi, 3);
    for (int j = 0; j < int'(TO); j++) begin
      check("to_meas", pack(j == 0, 1'b1, lat_hi, 1'b0, 3'b011, 8'(exp_count)));
      step();
    end
    check("fault", pack(1'b0, 1'b0, 4'b0000, 1'b0, 3'b100, 8'(exp_count)));
    bus.adc_measure_valid_i = 1'b1;
    step();
    bus.adc_measure_valid_i = 1'b0;
    step();
    check("fault_hold", pack(1'b0, 1'b0, 4'b0000, 1'b0, 3'b100, 8'(exp_count)));
    disarm_check("fault_exit");

    // Asynchronous reset in the middle of MEAS_LO.
    arm_start(0, 4'h2, 4'h4);
    pc_phase(1'b1, lat_hi, 1);
    meas_phase(1'b1, lat_hi, 1, 1'b0);
    pc_phase(1'b0, lat_lo, 1);
    check("rst_ml_trig", pack(1'b1, 1'b0, lat_lo, 1'b0, 3'b001, 8'(exp_count)));
    step();
    #2 reset_n = 1'b0;
    #1;
    exp_count = 0;
    exp_mc = 1'b0;
    check("reset_async", pack(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 8'd0));
    bus.arm_i = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_reset_idle", pack(1'b0, 1'b0, 4'b0000, 1'b0, 3'b000, 8'd0));
    end

    // P=0, 256 pairs: single-cycle precharge and counter wrap.
    arm_start(0, 4'h1, 4'hF);
    for (int k = 0; k < 256; k++) pair(1, 1, 1'b0);
    check("wrap", pack(1'b0, 1'b0, 4'h1, 1'b1, 3'b011, 8'd0));
    disarm_check("wrap_idle");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/sample_acquisition_az.md
# sample_acquisition_az

Auto-zero sample-acquisition sequencer. It alternates the input mux between a signal input (HI) and a zero input (LO). Each phase gets a precharge interval and then an ADC measurement, handshaken with the ADC measure engine through a trigger pulse and a completion pulse. It drives the precharge switch, `azmux_o` and `meas_complete_o` through the top-level mode/alternate-function mux, and exposes status for `reg_status`.

## Interface
- `TIMEOUT`, default 24'd10_000_000: clocks to wait in a measure state for `adc_measure_valid_i` before faulting.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `arm_i`  in  1  level; high runs the sequence continuously, low returns to IDLE.
- `p_clk_count_precharge`  in  24  precharge length parameter, latched at arm.
- `p_azmux_hi`  in  4  azmux code for the signal input, latched at arm.
- `p_azmux_lo`  in  4  azmux code for the zero input, latched at arm.
- `adc_measure_valid_i`  in  1  one-cycle pulse from the ADC when its measurement is complete.
- `adc_measure_trig_o`  out  1  one-cycle pulse that starts an ADC measurement.
- `sw_pc_ctl_o`  out  1  precharge switch; 1 = signal path connected, 0 = isolated/precharge.
- `azmux_o`  out  4  az mux select.
- `meas_complete_o`  out  1  level; set when a HI/LO pair completes.
- `az_status_o`  out  3  {fault, phase_is_hi, busy}.
- `sample_count_o`  out  8  count of completed pairs, wraps.

## Operation
- States: IDLE, PC_HI, MEAS_HI, PC_LO, MEAS_LO, FAULT.
- All outputs are registered.
- Reset and IDLE output values:
  - trig=0, sw_pc=0, azmux=4'b0000, meas_complete=0, status=3'b000.
  - sample_count is 0 on reset only; IDLE holds its value.
- IDLE -> PC_HI when `arm_i`=1.
  - On this transition, latch `p_clk_count_precharge`, `p_azmux_hi` and `p_azmux_lo`.
  - Clear the 24-bit phase counter.
- PC_x (precharge):
  - sw_pc=0; azmux = latched hi code (PC_HI) or lo code (PC_LO).
  - Each cycle: if counter == latched precharge value, go to MEAS_x and clear the counter; otherwise increment the counter.
  - A precharge value of 0 therefore gives 1 cycle of precharge.
- MEAS_x (measure):
  - azmux is held.
  - sw_pc=1 in MEAS_HI and 0 in MEAS_LO.
  - `adc_measure_trig_o`=1 in the first MEAS_x cycle only.
  - `adc_measure_valid_i` is ignored in the trigger cycle and accepted in every later MEAS cycle.
  - On an accepted valid: MEAS_HI -> PC_LO; MEAS_LO -> PC_HI, with meas_complete set to 1 and sample_count incremented (mod 256).
  - The counter runs during MEAS_x. When it reaches TIMEOUT-1 without an accepted valid, go to FAULT.
- meas_complete clears in the cycle MEAS_HI issues its trigger. It is a level that stays high through the next PC_HI.
- `adc_measure_valid_i` outside MEAS_x (after the trigger cycle) is ignored and has no effect.
- FAULT:
  - Outputs as in IDLE, except fault=1.
  - Leave FAULT only when `arm_i`=0, going to IDLE; fault clears on that exit.
- `arm_i`=0 in any non-IDLE state: go to IDLE at the next edge and abort the current phase.
  - No trigger is issued and meas_complete is not set.
  - A valid arriving in that same cycle is discarded.
- status bits:
  - busy = 1 in PC_x and MEAS_x.
  - phase_is_hi = 1 in PC_HI and MEAS_HI.
- Changes to the input parameters while armed have no effect until the next arm.

## Timing
- Edge numbering: `arm_i` is sampled high at edge 0.
  - State is PC_HI and azmux = hi code after edge 0.
  - PC_HI lasts P+1 cycles, where P is the latched precharge value.
  - State becomes MEAS_HI after edge P+1, with trigger high for cycle P+1 only.
- Valid accepted at edge k -> PC_LO from edge k onward. LO timing mirrors HI timing.
- meas_complete rises in the same cycle the state enters PC_HI after MEAS_LO.
- Minimum period of one HI/LO pair with P=0 and valid one cycle after each trigger: 6 cycles.
- `reset_n` low asynchronously forces all reset values, including sample_count=0, regardless of state.
- Release of `reset_n` is synchronised by the top level; the block does not synchronise it.

## Test plan
- **Reset:** assert `reset_n` low mid-MEAS_LO -> all outputs go to 0 immediately; after release with `arm_i`=0, the block stays in IDLE.
- **Single pair:** P=3, hi=4'b1001, lo=4'b0011; respond to each trigger with valid 5 cycles later ->
  - azmux=1001 for 4 PC cycles, then trigger with sw_pc=1;
  - then azmux=0011 for 4 cycles, then trigger with sw_pc=0;
  - then meas_complete=1 and sample_count=1.
- **Early valid:** valid coincident with the trigger cycle -> ignored; the state stays MEAS_HI until a later valid.
- **Timeout:** TIMEOUT=16 and valid never arrives -> FAULT after 16 MEAS cycles and status=3'b100; `arm_i`=0 -> IDLE with status=3'b000.
- **Abort:** drop `arm_i` during PC_LO -> IDLE next edge, azmux=0000, no trigger; re-arm -> restarts at PC_HI with newly latched parameters.
- **Wrap and P=0:** P=0 with 256 pairs -> sample_count wraps to 0 and each PC phase is exactly 1 cycle.
